// File: rtl/thee_clk_pkg.sv
// Shared types and constants for the programmable clock-divider controller.
package thee_clk_pkg;

  localparam int DIV_W_DEF = 16;
  localparam int MIN_DIV   = 2;

  typedef logic [DIV_W_DEF-1:0] div_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } clk_div_state_e;

endpackage

// File: rtl/thee_clk_div_counter.sv
// Period counter for the clock divider. last_cycle/high_phase describe the
// cycle after the coming edge so the top can register them with no lag.
module thee_clk_div_counter
  import thee_clk_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             run_nxt,
  input  logic [DIV_W-1:0] div,
  input  logic [DIV_W-1:0] div_nxt,
  output logic             last_cycle,
  output logic             high_phase
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] cnt_nxt;
  logic [DIV_W-1:0] half_nxt;
  logic             wrap;

  assign wrap     = (cnt == div - DIV_W'(1));
  assign cnt_nxt  = (run && !wrap) ? cnt + DIV_W'(1) : '0;
  // ceil(d/2) without risking overflow at the top of the range
  assign half_nxt = (div_nxt >> 1) + {{(DIV_W-1){1'b0}}, div_nxt[0]};

  assign last_cycle = run_nxt && (cnt_nxt == div_nxt - DIV_W'(1));
  assign high_phase = run_nxt && (cnt_nxt >= half_nxt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/thee_clk_div_ctrl.sv
// Clock-divider controller: glitch-free start/stop sequencing, divided clock,
// period strobe and a req/ack divisor update applied only at period boundaries.
module thee_clk_div_ctrl
  import thee_clk_pkg::*;
#(
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 4,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             cfg_req,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ack,
  output logic             cfg_err,
  output logic             div_clk,
  output logic             clk_en,
  output logic             busy,
  output logic [DIV_W-1:0] cur_div,
  output logic [CNT_W-1:0] period_cnt
);

  logic [1:0]       rst_sync;
  logic             rst_int_n;
  clk_div_state_e   state;
  clk_div_state_e   state_nxt;
  logic [DIV_W-1:0] div_nxt;
  logic             req_live;
  logic             div_ok;
  logic             cfg_apply;
  logic             cfg_rej;
  logic             last_cycle;
  logic             high_phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync <= '0;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end
  assign rst_int_n = rst_sync[1];

  // clk_en is high exactly on the last cycle of a running period
  assign req_live  = cfg_req && !cfg_ack;
  assign div_ok    = (cfg_div >= DIV_W'(MIN_DIV));
  assign cfg_apply = req_live && div_ok && ((state == IDLE) || clk_en);
  assign cfg_rej   = req_live && !div_ok;
  assign div_nxt   = cfg_apply ? cfg_div : cur_div;

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start && !stop) state_nxt = RUN;
      RUN:      if (stop)           state_nxt = STOPPING;
      STOPPING: if (clk_en)         state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  thee_clk_div_counter #(.DIV_W(DIV_W)) u_counter (
    .clk        (clk),
    .rst_n      (rst_int_n),
    .run        (state != IDLE),
    .run_nxt    (state_nxt != IDLE),
    .div        (cur_div),
    .div_nxt    (div_nxt),
    .last_cycle (last_cycle),
    .high_phase (high_phase)
  );

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      cur_div    <= DIV_W'(DEFAULT_DIV);
      period_cnt <= '0;
      div_clk    <= 1'b0;
      clk_en     <= 1'b0;
      busy       <= 1'b0;
      cfg_ack    <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      cur_div <= div_nxt;
      if (clk_en) period_cnt <= period_cnt + CNT_W'(1);
      div_clk <= high_phase;
      clk_en  <= last_cycle;
      busy    <= (state_nxt != IDLE);
      cfg_ack <= cfg_apply || cfg_rej;
      cfg_err <= cfg_rej;
    end
  end

endmodule
